// File: rtl/botun_game_ctrl.sv
// Four-button reaction game sequencer: debounced keys, pseudo-random target,
// per-round seconds countdown, score/lives bookkeeping and win/game-over detection.
module botun_game_ctrl #(
  parameter int unsigned TICK_DIV      = 25_000_000,
  parameter int unsigned DEBOUNCE_CYC  = 250_000,
  parameter int unsigned ROUND_SECONDS = 9,
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned MAX_SCORE     = 9,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  input  logic       start,
  output logic [1:0] target,
  output logic [3:0] countdown,
  output logic [3:0] score,
  output logic [1:0] lives,
  output logic       round_active,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       game_over,
  output logic       win
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int TK_W = $clog2(TICK_DIV + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, ARM, WAIT, OVER} state_e;

  logic [3:0]      sync1_q, sync2_q, acc_q, press_q;
  logic [DB_W-1:0] db_cnt_q [4];

  state_e          state_q;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [TK_W-1:0] tick_q;
  logic [1:0]      target_q, cand;
  logic [3:0]      countdown_q, score_q;
  logic [1:0]      lives_q;
  logic            hit_q, miss_q, win_q;
  logic            tick, hit_ev, miss_ev;

  // Key path: two-flop synchroniser, per-bit stability counter, rising-edge press strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      acc_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
      for (int i = 0; i < 4; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] == acc_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_cnt_q[i] <= '0;
          acc_q[i]    <= sync2_q[i];
          press_q[i]  <= sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign cand   = lfsr_q[1:0];
  assign tick   = (tick_q == TK_LAST);
  // A press always outranks the tick; more than one simultaneous press never matches the mask
  assign hit_ev  = (press_q == (4'b0001 << target_q));
  assign miss_ev = (|press_q && !hit_ev) || (press_q == 4'b0000 && tick && countdown_q == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= LFSR_SEED;
      tick_q      <= '0;
      target_q    <= '0;
      countdown_q <= '0;
      score_q     <= '0;
      lives_q     <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        IDLE, OVER: begin
          if (start) begin
            score_q <= '0;
            lives_q <= 2'(START_LIVES);
            win_q   <= 1'b0;
            state_q <= ARM;
          end
        end
        ARM: begin
          target_q    <= (cand == target_q) ? target_q + 2'd1 : cand;
          countdown_q <= 4'(ROUND_SECONDS);
          tick_q      <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          tick_q <= tick ? '0 : tick_q + TK_W'(1);
          if (hit_ev) begin
            score_q <= score_q + 4'd1;
            hit_q   <= 1'b1;
            if (score_q + 4'd1 == 4'(MAX_SCORE)) begin
              win_q   <= 1'b1;
              state_q <= OVER;
            end else begin
              state_q <= ARM;
            end
          end else if (miss_ev) begin
            miss_q <= 1'b1;
            if (lives_q != 2'd0) lives_q <= lives_q - 2'd1;
            state_q <= (lives_q <= 2'd1) ? OVER : ARM;
          end else if (tick) begin
            countdown_q <= countdown_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign target       = target_q;
  assign countdown    = countdown_q;
  assign score        = score_q;
  assign lives        = lives_q;
  assign round_active = (state_q == WAIT);
  assign hit_pulse    = hit_q;
  assign miss_pulse   = miss_q;
  assign game_over    = (state_q == OVER);
  assign win          = win_q;

endmodule
